// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider: FSM state encoding and
// default operand/tag widths.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_TAG_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_e;

endpackage

// File: rtl/seq_divider_if.sv
// Request/result bundle between an issuing reservation station and the divider.
// Handshake: start is taken on a rising edge while ready=1; a result is held
// while out_valid=1 and is consumed on the rising edge where out_ack=1.
interface seq_divider_if #(
  parameter int WIDTH = div_pkg::DIV_WIDTH,
  parameter int TAG_W = div_pkg::DIV_TAG_W
);

  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic [TAG_W-1:0] tag_in;
  logic             ready;
  logic             out_valid;
  logic             out_ack;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic [TAG_W-1:0] tag_out;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor, tag_in, out_ack,
    input  ready, out_valid, quotient, remainder, tag_out, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor, tag_in, out_ack,
    output ready, out_valid, quotient, remainder, tag_out, div_by_zero
  );

endinterface

// File: rtl/div_sub_stage.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor, and keep the difference only when it did not go negative.
module div_sub_stage #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic             bit_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH-1:0] rem_o,
  output logic             qbit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  assign shifted = {rem_i, bit_i};
  assign diff    = shifted - {1'b0, divisor_i};
  // shifted < 2*divisor always holds, so a set MSB of diff means a borrow.
  assign qbit_o  = ~diff[WIDTH];
  assign rem_o   = qbit_o ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];

endmodule

// File: rtl/seq_divider.sv
// Radix-2 restoring divider producing one quotient bit per cycle, with a
// tagged result held for common-data-bus broadcast until acknowledged.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int TAG_W = DIV_TAG_W
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_divider_if.slave        bus,
  output div_state_e          state_dbg_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  div_state_e       state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] work_q;
  logic [WIDTH-1:0] dvs_q;
  logic [TAG_W-1:0] tag_q;
  logic [WIDTH-1:0] quotient_q;
  logic [WIDTH-1:0] remainder_q;
  logic [TAG_W-1:0] tag_out_q;
  logic             dbz_q;

  logic [WIDTH-1:0] rem_d;
  logic             qbit_d;

  // work_q starts as the dividend; its MSB feeds each step while quotient
  // bits shift in from the bottom.
  div_sub_stage #(.WIDTH(WIDTH)) u_stage (
    .rem_i     (rem_q),
    .bit_i     (work_q[WIDTH-1]),
    .divisor_i (dvs_q),
    .rem_o     (rem_d),
    .qbit_o    (qbit_d)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      work_q      <= '0;
      dvs_q       <= '0;
      tag_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      tag_out_q   <= '0;
      dbz_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            dvs_q  <= bus.divisor;
            work_q <= bus.dividend;
            rem_q  <= '0;
            tag_q  <= bus.tag_in;
            if (bus.divisor == '0) begin
              quotient_q  <= '1;
              remainder_q <= bus.dividend;
              tag_out_q   <= bus.tag_in;
              dbz_q       <= 1'b1;
              state_q     <= DONE;
            end else begin
              cnt_q   <= CNT_W'(WIDTH);
              state_q <= RUN;
            end
          end
        end
        RUN: begin
          rem_q  <= rem_d;
          work_q <= {work_q[WIDTH-2:0], qbit_d};
          cnt_q  <= cnt_q - CNT_W'(1);
          // Final step lands straight in the result registers so the
          // visible outputs never show partial values.
          if (cnt_q == CNT_W'(1)) begin
            quotient_q  <= {work_q[WIDTH-2:0], qbit_d};
            remainder_q <= rem_d;
            tag_out_q   <= tag_q;
            dbz_q       <= 1'b0;
            state_q     <= DONE;
          end
        end
        DONE: begin
          if (bus.out_ack) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.out_valid   = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.tag_out     = tag_out_q;
  assign bus.div_by_zero = dbz_q;
  assign state_dbg_o     = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider: directed corner cases followed by a
// randomized regression against an arithmetic reference model.
module tb_seq_divider;
  import div_pkg::*;

  localparam int W  = 32;
  localparam int TW = 6;

  typedef struct {
    logic [W-1:0]  a;
    logic [W-1:0]  b;
    logic [W-1:0]  q;
    logic [W-1:0]  r;
    logic [TW-1:0] tag;
    logic          dbz;
    int            cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  div_state_e state_dbg;
  int         cyc;
  int         total;
  int         bad;
  int         ack_fixed;
  bit         checked;
  exp_t       exp_q[$];
  exp_t       cur;

  seq_divider_if #(.WIDTH(W), .TAG_W(TW)) bus ();

  seq_divider #(.WIDTH(W), .TAG_W(TW)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus),
    .state_dbg_o (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_ready"},     64'(bus.ready), 64'd1);
    chk({pfx, "_out_valid"}, 64'(bus.out_valid), 64'd0);
    chk({pfx, "_dbz"},       64'(bus.div_by_zero), 64'd0);
    chk({pfx, "_quotient"},  64'(bus.quotient), 64'd0);
    chk({pfx, "_remainder"}, 64'(bus.remainder), 64'd0);
    chk({pfx, "_tag_out"},   64'(bus.tag_out), 64'd0);
    chk({pfx, "_state"},     64'(state_dbg), 64'(IDLE));
  endtask

  function automatic logic [W-1:0] rand_val();
    case ($urandom_range(0, 7))
      0:       return '0;
      1:       return W'(1);
      2:       return '1;
      3:       return W'($urandom_range(0, 15));
      default: return W'($urandom);
    endcase
  endfunction

  // ---------------- driver ----------------
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [TW-1:0] tag, input bit push);
    exp_t e;
    int   waited;
    waited = 0;
    while (!bus.ready) begin
      @(negedge clk);
      waited++;
      if (waited > 100) begin
        chk("ready_timeout", 64'(bus.ready), 64'd1);
        return;
      end
    end
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    bus.tag_in   = tag;
    if (push) begin
      e.a   = a;
      e.b   = b;
      e.tag = tag;
      e.dbz = (b == 0);
      e.q   = (b == 0) ? '1 : a / b;
      e.r   = (b == 0) ? a : a % b;
      e.cyc = cyc + ((b == 0) ? 1 : W + 1);
      exp_q.push_back(e);
    end
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic pulse_junk_start();
    bus.start    = 1'b1;
    bus.dividend = W'($urandom);
    bus.divisor  = W'(0);
    bus.tag_in   = TW'(63);
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc);
    int n;
    n = 0;
    while (!bus.out_valid) begin
      @(negedge clk);
      n++;
      if (n > max_cyc) begin
        chk("valid_timeout", 64'(bus.out_valid), 64'd1);
        return;
      end
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (exp_q.size() != 0 || !bus.ready) begin
      @(negedge clk);
      n++;
      if (n > 200) begin
        chk("idle_timeout", 64'(exp_q.size()), 64'd0);
        return;
      end
    end
  endtask

  // ---------------- consumer acknowledge ----------------
  initial begin
    int d;
    forever begin
      @(negedge clk);
      if (rst_n && bus.out_valid) begin
        d = (ack_fixed >= 0) ? ack_fixed : $urandom_range(0, 3);
        repeat (d) @(negedge clk);
        bus.out_ack = 1'b1;
        @(negedge clk);
        bus.out_ack = 1'b0;
      end
    end
  end

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    if (!rst_n || !bus.out_valid) begin
      checked = 1'b0;
    end else if (!checked) begin
      checked = 1'b1;
      if (exp_q.size() == 0) begin
        chk("unexpected_result", 64'(bus.out_valid), 64'd0);
      end else begin
        cur = exp_q.pop_front();
        chk("quotient",  64'(bus.quotient), 64'(cur.q));
        chk("remainder", 64'(bus.remainder), 64'(cur.r));
        chk("tag_out",   64'(bus.tag_out), 64'(cur.tag));
        chk("dbz",       64'(bus.div_by_zero), 64'(cur.dbz));
        chk("latency",   64'(cyc), 64'(cur.cyc));
        if (!cur.dbz) begin
          chk("identity", 64'(bus.quotient) * 64'(cur.b) + 64'(bus.remainder), 64'(cur.a));
          chk("rem_lt_div", 64'(bus.remainder < cur.b), 64'd1);
        end
      end
    end else begin
      chk("hold_quotient",  64'(bus.quotient), 64'(cur.q));
      chk("hold_remainder", 64'(bus.remainder), 64'(cur.r));
      chk("hold_tag",       64'(bus.tag_out), 64'(cur.tag));
      chk("hold_dbz",       64'(bus.div_by_zero), 64'(cur.dbz));
    end
  end

  // ---------------- main sequence ----------------
  initial begin
    total        = 0;
    bad          = 0;
    checked      = 1'b0;
    ack_fixed    = 3;
    rst_n        = 1'b0;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    bus.tag_in   = '0;
    bus.out_ack  = 1'b0;

    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;

    // 100/7 with a stray ack during RUN
    do_op(32'd100, 32'd7, 6'd5, 1'b1);
    bus.out_ack = 1'b1;
    @(negedge clk);
    bus.out_ack = 1'b0;
    wait_idle();

    // Edge values, back to back
    do_op(32'hFFFF_FFFF, 32'd1, 6'd1, 1'b1);
    do_op(32'd7, 32'd100, 6'd2, 1'b1);
    do_op(32'd5, 32'd0, 6'd3, 1'b1);
    do_op(32'd0, 32'd9, 6'd4, 1'b1);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 6'd6, 1'b1);
    do_op(32'h8000_0000, 32'd3, 6'd7, 1'b1);
    wait_idle();

    // Long ack hold with starts pulsed in RUN and DONE
    ack_fixed = 10;
    do_op(32'd1234, 32'd5, 6'd11, 1'b1);
    repeat (5) @(negedge clk);
    pulse_junk_start();
    wait_valid(40);
    pulse_junk_start();
    begin
      int n;
      n = 0;
      do begin
        @(posedge clk);
        n++;
      end while (!bus.out_ack && n < 30);
    end
    @(negedge clk);
    chk("ack_then_ready", 64'(bus.ready), 64'd1);
    chk("ack_then_invalid", 64'(bus.out_valid), 64'd0);
    wait_idle();

    // Start in the same cycle as the acknowledge must be ignored
    ack_fixed = 0;
    do_op(32'd20, 32'd4, 6'd9, 1'b1);
    wait_valid(40);
    pulse_junk_start();
    chk("start_with_ack_ready", 64'(bus.ready), 64'd1);
    chk("start_with_ack_state", 64'(state_dbg), 64'(IDLE));
    repeat (3) @(negedge clk);
    chk("start_with_ack_no_result", 64'(bus.out_valid), 64'd0);
    wait_idle();

    // Reset mid-operation, then an immediate accept after release
    ack_fixed = -1;
    do_op(32'd1000, 32'd3, 6'd12, 1'b0);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrun_reset");
    @(negedge clk);
    rst_n = 1'b1;
    do_op(32'd9, 32'd2, 6'd13, 1'b1);
    wait_idle();

    // Randomized regression
    for (int i = 0; i < 1200; i++) begin
      do_op(rand_val(), rand_val(), TW'($urandom_range(0, 63)), 1'b1);
    end
    wait_idle();
    repeat (5) @(negedge clk);
    chk("final_queue_empty", 64'(exp_q.size()), 64'd0);
    chk("final_idle", 64'(bus.ready), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
